// File: rtl/xadc_drp_responder.sv
// xadc_drp_responder
// Simulation / bring-up stand-in for the XADC DRP responder. Joystick samples
// (aux6 = X, aux7 = Y) are turned into result registers after a fixed conversion
// time, and DRP requests are answered after a fixed latency.
// Optional feature macro: XADC_DRP_MINMAX_EN adds per-channel min/max tracking
// registers at 7'h28/7'h29 (max) and 7'h2C/7'h2D (min).
//
// DRP FSM states:
//   state  | meaning
//   IDLE   | no transaction pending, den accepted
//   WAIT   | latency countdown, den here is a collision
//   DONE   | o_drdy cycle, write committed, den accepted back-to-back
// Conversion FSM states:
//   state  | meaning
//   IDLE   | ready for a new sample
//   CONV   | conversion countdown, new samples dropped
module xadc_drp_responder #(
    parameter int         DRP_LAT     = 4,
    parameter int         CONV_CYCLES = 26,
    parameter logic [6:0] ADDR_CH0    = 7'h16,
    parameter logic [6:0] ADDR_CH1    = 7'h17
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_den,
    input  logic        i_dwe,
    input  logic [6:0]  i_daddr,
    input  logic [15:0] i_di,
    output logic        o_drdy,
    output logic [15:0] o_do,
    input  logic        i_sample_valid,
    input  logic        i_sample_ch,
    input  logic [11:0] i_sample_data,
    output logic        o_sample_ready,
    output logic        o_busy,
    output logic        o_eoc,
    output logic        o_eos,
    output logic [4:0]  o_channel,
    output logic        o_collision
);

    localparam logic [1:0] DRP_IDLE = 2'd0;
    localparam logic [1:0] DRP_WAIT = 2'd1;
    localparam logic [1:0] DRP_DONE = 2'd2;

    localparam logic [0:0] CV_IDLE = 1'b0;
    localparam logic [0:0] CV_CONV = 1'b1;

    localparam logic [3:0] DRP_LOAD  = 4'(DRP_LAT - 1);
    localparam logic [7:0] CONV_LOAD = 8'(CONV_CYCLES - 1);

    logic [1:0]  r_drp_st;
    logic [3:0]  r_drp_cnt;
    logic [6:0]  r_addr;
    logic        r_we;
    logic [15:0] r_di;
    logic [15:0] r_rdata;
    logic        r_drdy;
    logic [15:0] r_do;
    logic        r_coll;

    logic [0:0]  r_cv_st;
    logic [7:0]  r_cv_cnt;
    logic        r_cv_ch;
    logic [11:0] r_cv_data;
    logic        r_eoc;
    logic        r_eos;
    logic [4:0]  r_channel;

    logic [15:0] r_res0;
    logic [15:0] r_res1;
    logic [15:0] r_scr0;
    logic [15:0] r_scr1;
    logic [15:0] r_scr2;

    logic [15:0] w_rd_data;
    logic        w_commit;
    logic        w_conv_done;
    logic [15:0] w_cv_val;

    assign w_commit    = (r_drp_st == DRP_WAIT) && (r_drp_cnt == 4'd0) && r_we;
    assign w_conv_done = (r_cv_st == CV_CONV) && (r_cv_cnt == 8'd0);
    assign w_cv_val    = {r_cv_data, 4'b0000};

`ifdef XADC_DRP_MINMAX_EN
    logic [15:0] r_max0;
    logic [15:0] r_max1;
    logic [15:0] r_min0;
    logic [15:0] r_min1;

    // Track running extremes per channel, updated together with o_eoc
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_max0 <= 16'h0000;
            r_max1 <= 16'h0000;
            r_min0 <= 16'hFFF0;
            r_min1 <= 16'hFFF0;
        end else if (w_conv_done) begin
            if (!r_cv_ch) begin
                if (w_cv_val > r_max0) r_max0 <= w_cv_val;
                if (w_cv_val < r_min0) r_min0 <= w_cv_val;
            end else begin
                if (w_cv_val > r_max1) r_max1 <= w_cv_val;
                if (w_cv_val < r_min1) r_min1 <= w_cv_val;
            end
        end
    end
`endif

    // Register-file read decode on the live request address (snapshotted on accept)
    always_comb begin
        w_rd_data = 16'h0000;
        if (i_daddr == ADDR_CH0) begin
            w_rd_data = r_res0;
        end else if (i_daddr == ADDR_CH1) begin
            w_rd_data = r_res1;
        end else begin
            case (i_daddr)
                7'h40:   w_rd_data = r_scr0;
                7'h41:   w_rd_data = r_scr1;
                7'h42:   w_rd_data = r_scr2;
`ifdef XADC_DRP_MINMAX_EN
                7'h28:   w_rd_data = r_max0;
                7'h29:   w_rd_data = r_max1;
                7'h2C:   w_rd_data = r_min0;
                7'h2D:   w_rd_data = r_min1;
`endif
                default: w_rd_data = 16'h0000;
            endcase
        end
    end

    // DRP request FSM: accept, count down latency, emit drdy/do
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drp_st  <= DRP_IDLE;
            r_drp_cnt <= 4'd0;
            r_addr    <= 7'd0;
            r_we      <= 1'b0;
            r_di      <= 16'h0000;
            r_rdata   <= 16'h0000;
            r_drdy    <= 1'b0;
            r_do      <= 16'h0000;
            r_coll    <= 1'b0;
        end else begin
            r_drdy <= 1'b0;
            r_do   <= 16'h0000;
            case (r_drp_st)
                DRP_IDLE, DRP_DONE: begin
                    if (i_den) begin
                        r_drp_st  <= DRP_WAIT;
                        r_drp_cnt <= DRP_LOAD;
                        r_addr    <= i_daddr;
                        r_we      <= i_dwe;
                        r_di      <= i_di;
                        r_rdata   <= w_rd_data;
                    end else begin
                        r_drp_st <= DRP_IDLE;
                    end
                end
                DRP_WAIT: begin
                    if (i_den) r_coll <= 1'b1;
                    if (r_drp_cnt == 4'd0) begin
                        r_drp_st <= DRP_DONE;
                        r_drdy   <= 1'b1;
                        r_do     <= r_rdata;
                    end else begin
                        r_drp_cnt <= r_drp_cnt - 4'd1;
                    end
                end
                default: r_drp_st <= DRP_IDLE;
            endcase
        end
    end

    // Scratch writes land on the edge that raises o_drdy; result addresses are read-only
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scr0 <= 16'h0000;
            r_scr1 <= 16'h0000;
            r_scr2 <= 16'h0000;
        end else if (w_commit) begin
            case (r_addr)
                7'h40:   r_scr0 <= r_di;
                7'h41:   r_scr1 <= r_di;
                7'h42:   r_scr2 <= r_di;
                default: ;
            endcase
        end
    end

    // Conversion FSM: latch sample, count down, publish result with eoc/eos
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cv_st   <= CV_IDLE;
            r_cv_cnt  <= 8'd0;
            r_cv_ch   <= 1'b0;
            r_cv_data <= 12'h000;
            r_eoc     <= 1'b0;
            r_eos     <= 1'b0;
            r_channel <= 5'd0;
            r_res0    <= 16'h0000;
            r_res1    <= 16'h0000;
        end else begin
            r_eoc <= 1'b0;
            r_eos <= 1'b0;
            case (r_cv_st)
                CV_IDLE: begin
                    if (i_sample_valid) begin
                        r_cv_st   <= CV_CONV;
                        r_cv_cnt  <= CONV_LOAD;
                        r_cv_ch   <= i_sample_ch;
                        r_cv_data <= i_sample_data;
                    end
                end
                CV_CONV: begin
                    if (r_cv_cnt == 8'd0) begin
                        r_cv_st <= CV_IDLE;
                        r_eoc   <= 1'b1;
                        r_eos   <= r_cv_ch;
                        if (r_cv_ch) begin
                            r_res1    <= w_cv_val;
                            r_channel <= ADDR_CH1[4:0];
                        end else begin
                            r_res0    <= w_cv_val;
                            r_channel <= ADDR_CH0[4:0];
                        end
                    end else begin
                        r_cv_cnt <= r_cv_cnt - 8'd1;
                    end
                end
                default: r_cv_st <= CV_IDLE;
            endcase
        end
    end

    assign o_drdy         = r_drdy;
    assign o_do           = r_do;
    assign o_collision    = r_coll;
    assign o_busy         = (r_cv_st == CV_CONV);
    assign o_sample_ready = ~o_busy;
    assign o_eoc          = r_eoc;
    assign o_eos          = r_eos;
    assign o_channel      = r_channel;

endmodule
